// File: rtl/hqm_aw_beat_unpacker.sv
// hqm_aw_beat_unpacker
//   Splits a packed multi-beat word into a stream of WIDTH-bit beats, beat 0
//   first (beat k = in_data[k*WIDTH +: WIDTH]). Holds one word at a time and
//   reloads on the same cycle the final beat leaves, so back-to-back words
//   stream at one beat per cycle with no bubble.
//
// Ports
//   clk, rst     : rising-edge clock, synchronous active-high reset
//   in_valid     : input word valid (from quad buffer out_valid)
//   in_ready     : word can be accepted this cycle (to quad buffer out_ready)
//   in_data      : packed word, NUM_BEATS beats of WIDTH bits
//   in_nbeats    : valid beats in the word; 0 means NUM_BEATS, values above
//                  NUM_BEATS are clamped and flagged on err_nbeats
//   out_valid    : beat valid
//   out_ready    : downstream accepts beat
//   out_data     : current beat
//   out_last     : current beat is the final beat of its word
//   err_nbeats   : one-cycle pulse after a word with an oversize count is taken
//   status       : registered {in_stall, in_taken, out_stall, out_taken,
//                  out_ready, beat_idx[2:0]}
module hqm_aw_beat_unpacker #(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned NUM_BEATS      = 4,
  parameter bit          RESET_DATAPATH = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH*NUM_BEATS-1:0] in_data,
  input  logic [2:0]                 in_nbeats,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_last,
  output logic                       err_nbeats,
  output logic [7:0]                 status
);

  localparam logic [3:0] NB_MAX = 4'(NUM_BEATS);

  logic                       hold_valid;
  logic [WIDTH*NUM_BEATS-1:0] hold_data;
  // One bit wider than the 3-bit input count so NUM_BEATS=8 is representable;
  // the reset value 0 keeps out_last low until the first word loads.
  logic [3:0]                 hold_n;
  logic [2:0]                 beat_idx;

  logic       in_taken;
  logic       out_taken;
  logic [3:0] dec_n;
  logic       nbeats_ovf;

  always_comb begin
    nbeats_ovf = ({1'b0, in_nbeats} > NB_MAX);
    dec_n      = {1'b0, in_nbeats};
    if ((in_nbeats == 3'd0) || nbeats_ovf) begin
      dec_n = NB_MAX;
    end
  end

  assign out_valid = hold_valid;
  assign out_data  = hold_data[beat_idx*WIDTH +: WIDTH];
  assign out_last  = ({1'b0, beat_idx} == (hold_n - 4'd1));

  assign out_taken = out_valid & out_ready;
  // Only combinational path through the block: out_ready -> in_ready.
  assign in_ready  = ~hold_valid | (out_taken & out_last);
  assign in_taken  = in_valid & in_ready;

  // Control state. A load takes priority: in_taken while holding a word is
  // only possible when that word's last beat leaves in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_valid <= 1'b0;
      hold_n     <= '0;
      beat_idx   <= '0;
      err_nbeats <= 1'b0;
      status     <= '0;
    end else begin
      if (in_taken) begin
        hold_valid <= 1'b1;
        hold_n     <= dec_n;
        beat_idx   <= '0;
      end else if (out_taken) begin
        if (out_last) begin
          hold_valid <= 1'b0;
          beat_idx   <= '0;
        end else begin
          beat_idx <= beat_idx + 3'd1;
        end
      end
      err_nbeats <= in_taken & nbeats_ovf;
      status     <= {in_valid & ~in_ready, in_taken,
                     out_valid & ~out_ready, out_taken,
                     out_ready, beat_idx};
    end
  end

  // Word holding register; reset only when RESET_DATAPATH is set.
  always_ff @(posedge clk) begin
    if (RESET_DATAPATH && rst) begin
      hold_data <= '0;
    end else if (in_taken) begin
      hold_data <= in_data;
    end
  end

endmodule

// File: tb/tb_hqm_aw_beat_unpacker.sv
module tb_hqm_aw_beat_unpacker;

  localparam int unsigned W  = 8;
  localparam int unsigned NB = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W*NB-1:0] in_data;
  logic [2:0]    in_nbeats;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic          out_last;
  logic          err_nbeats;
  logic [7:0]    status;

  int n_cmp = 0;
  int n_bad = 0;

  hqm_aw_beat_unpacker #(
    .WIDTH(W),
    .NUM_BEATS(NB),
    .RESET_DATAPATH(1'b0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .in_nbeats(in_nbeats),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_last(out_last),
    .err_nbeats(err_nbeats),
    .status(status)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0; in_nbeats = '0;
    @(negedge clk); @(negedge clk);
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    n_cmp++; if (out_last !== 1'b0) begin n_bad++; $display("FAIL reset_out_last got %b want 0", out_last); end
    n_cmp++; if (status !== 8'h00) begin n_bad++; $display("FAIL reset_status got %h want 00", status); end
    n_cmp++; if (err_nbeats !== 1'b0) begin n_bad++; $display("FAIL reset_err got %b want 0", err_nbeats); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_release_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_four_beat();
    logic [7:0] exp_d;
    @(negedge clk);
    in_valid = 1'b1; in_data = 32'h44332211; in_nbeats = 3'd0; out_ready = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL four_accept_ready got %b want 1", in_ready); end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      exp_d = 8'((k + 1) * 17);
      n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL four_valid beat %0d got %b want 1", k, out_valid); end
      n_cmp++; if (out_data !== exp_d) begin n_bad++; $display("FAIL four_data beat %0d got %h want %h", k, out_data, exp_d); end
      n_cmp++; if (out_last !== (k == 3)) begin n_bad++; $display("FAIL four_last beat %0d got %b want %b", k, out_last, (k == 3)); end
      n_cmp++; if (in_ready !== (k == 3)) begin n_bad++; $display("FAIL four_in_ready beat %0d got %b want %b", k, in_ready, (k == 3)); end
      if (k == 0) begin
        n_cmp++; if (status !== 8'h48) begin n_bad++; $display("FAIL four_status beat 0 got %h want 48", status); end
      end else begin
        n_cmp++; if (status !== (8'h18 | 8'(k - 1))) begin n_bad++; $display("FAIL four_status beat %0d got %h want %h", k, status, 8'h18 | 8'(k - 1)); end
      end
      n_cmp++; if (err_nbeats !== 1'b0) begin n_bad++; $display("FAIL four_err beat %0d got %b want 0", k, err_nbeats); end
    end
    @(negedge clk);
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL four_idle_valid got %b want 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_d [4];
    logic       exp_l [4];
    exp_d[0] = 8'h11; exp_d[1] = 8'h22; exp_d[2] = 8'h33; exp_d[3] = 8'h44;
    exp_l[0] = 1'b0;  exp_l[1] = 1'b1;  exp_l[2] = 1'b0;  exp_l[3] = 1'b1;
    @(negedge clk);
    in_valid = 1'b1; in_data = 32'h99992211; in_nbeats = 3'd2; out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 0) in_data = 32'h88884433;
      if (k == 2) in_valid = 1'b0;
      #1;
      n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL b2b_valid beat %0d got %b want 1", k, out_valid); end
      n_cmp++; if (out_data !== exp_d[k]) begin n_bad++; $display("FAIL b2b_data beat %0d got %h want %h", k, out_data, exp_d[k]); end
      n_cmp++; if (out_last !== exp_l[k]) begin n_bad++; $display("FAIL b2b_last beat %0d got %b want %b", k, out_last, exp_l[k]); end
      if (k == 1) begin
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_in_ready_on_last got %b want 1", in_ready); end
        n_cmp++; if (status !== 8'h98) begin n_bad++; $display("FAIL b2b_status_stall got %h want 98", status); end
      end
      if (k == 2) begin
        n_cmp++; if (status !== 8'h59) begin n_bad++; $display("FAIL b2b_status_reload got %h want 59", status); end
      end
    end
    @(negedge clk);
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_idle_valid got %b want 0", out_valid); end
  endtask

  task automatic test_stall();
    logic [7:0] exp_d [3];
    exp_d[0] = 8'hAA; exp_d[1] = 8'hBB; exp_d[2] = 8'hCC;
    @(negedge clk);
    in_valid = 1'b1; in_data = 32'hDDCCBBAA; in_nbeats = 3'd3; out_ready = 1'b0;
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      n_cmp++; if (out_data !== 8'hAA) begin n_bad++; $display("FAIL stall_data cycle %0d got %h want aa", s, out_data); end
      n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL stall_in_ready cycle %0d got %b want 0", s, in_ready); end
      n_cmp++; if (status !== ((s == 0) ? 8'h40 : 8'h20)) begin n_bad++; $display("FAIL stall_status cycle %0d got %h want %h", s, status, (s == 0) ? 8'h40 : 8'h20); end
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      out_ready = 1'b1;
      #1;
      n_cmp++; if (out_data !== exp_d[k]) begin n_bad++; $display("FAIL stall_drain_data beat %0d got %h want %h", k, out_data, exp_d[k]); end
      n_cmp++; if (out_last !== (k == 2)) begin n_bad++; $display("FAIL stall_drain_last beat %0d got %b want %b", k, out_last, (k == 2)); end
    end
    @(negedge clk);
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL stall_no_dd got valid %b data %h want valid 0", out_valid, out_data); end
  endtask

  task automatic test_nbeats();
    @(negedge clk);
    in_valid = 1'b1; in_data = 32'h04030201; in_nbeats = 3'd6; out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      n_cmp++; if (out_data !== 8'(k + 1)) begin n_bad++; $display("FAIL ovf_data beat %0d got %h want %h", k, out_data, 8'(k + 1)); end
      n_cmp++; if (out_last !== (k == 3)) begin n_bad++; $display("FAIL ovf_last beat %0d got %b want %b", k, out_last, (k == 3)); end
      n_cmp++; if (err_nbeats !== (k == 0)) begin n_bad++; $display("FAIL ovf_err beat %0d got %b want %b", k, err_nbeats, (k == 0)); end
    end
    @(negedge clk);
    in_valid = 1'b1; in_data = 32'h112233E5; in_nbeats = 3'd1;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL ovf_end_valid got %b want 0", out_valid); end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    n_cmp++; if (out_data !== 8'hE5) begin n_bad++; $display("FAIL single_data got %h want e5", out_data); end
    n_cmp++; if (out_last !== 1'b1) begin n_bad++; $display("FAIL single_last got %b want 1", out_last); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL single_in_ready got %b want 1", in_ready); end
    n_cmp++; if (err_nbeats !== 1'b0) begin n_bad++; $display("FAIL single_err got %b want 0", err_nbeats); end
    @(negedge clk);
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL single_done_valid got %b want 0", out_valid); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    in_valid = 1'b1; in_data = 32'hD4C3B2A1; in_nbeats = 3'd0; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    n_cmp++; if (out_data !== 8'hA1) begin n_bad++; $display("FAIL rstmid_beat0 got %h want a1", out_data); end
    @(negedge clk);
    #1;
    n_cmp++; if (out_data !== 8'hB2) begin n_bad++; $display("FAIL rstmid_beat1 got %h want b2", out_data); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_valid got %b want 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rstmid_in_ready got %b want 1", in_ready); end
    n_cmp++; if (status !== 8'h00) begin n_bad++; $display("FAIL rstmid_status got %h want 00", status); end
    in_valid = 1'b1; in_data = 32'h87654321; in_nbeats = 3'd2;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    n_cmp++; if (out_data !== 8'h21 || out_last !== 1'b0) begin n_bad++; $display("FAIL rstmid_new_beat0 got %h/%b want 21/0", out_data, out_last); end
    @(negedge clk);
    #1;
    n_cmp++; if (out_data !== 8'h43 || out_last !== 1'b1) begin n_bad++; $display("FAIL rstmid_new_beat1 got %h/%b want 43/1", out_data, out_last); end
    @(negedge clk);
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_new_done got %b want 0", out_valid); end
  endtask

  task automatic test_random();
    localparam int NW = 1000;
    logic [8:0] q [$];
    logic [8:0] e;
    logic       pend;
    logic       err_exp;
    logic       itake;
    int         sent;
    int         recv;
    int         cyc;
    int         n;
    pend = 1'b0; err_exp = 1'b0; sent = 0; recv = 0; cyc = 0;
    while ((recv < NW) && (cyc < 20000)) begin
      @(negedge clk);
      cyc++;
      if (!pend && (sent < NW) && ($urandom_range(0, 3) != 0)) begin
        pend = 1'b1;
        in_data = $urandom;
        in_nbeats = 3'($urandom_range(0, 7));
        sent++;
      end
      in_valid = pend;
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      n_cmp++; if (err_nbeats !== err_exp) begin n_bad++; $display("FAIL rnd_err cycle %0d got %b want %b", cyc, err_nbeats, err_exp); end
      n_cmp++; if (out_valid !== (q.size() != 0)) begin n_bad++; $display("FAIL rnd_valid cycle %0d got %b want %b", cyc, out_valid, q.size() != 0); end
      n_cmp++; if (in_ready !== ((q.size() == 0) || (out_ready && q.size() == 1))) begin n_bad++; $display("FAIL rnd_in_ready cycle %0d got %b want %b", cyc, in_ready, (q.size() == 0) || (out_ready && q.size() == 1)); end
      if (out_valid && out_ready && (q.size() != 0)) begin
        e = q.pop_front();
        n_cmp++; if ({out_last, out_data} !== e) begin n_bad++; $display("FAIL rnd_beat cycle %0d got %b/%h want %b/%h", cyc, out_last, out_data, e[8], e[7:0]); end
        if (e[8]) recv++;
      end
      itake = in_valid && in_ready;
      err_exp = itake && (in_nbeats > 3'd4);
      if (itake) begin
        n = ((in_nbeats == 3'd0) || (in_nbeats > 3'd4)) ? 4 : int'(in_nbeats);
        for (int k = 0; k < n; k++) q.push_back({(k == n - 1), in_data[k*8 +: 8]});
        pend = 1'b0;
      end
    end
    in_valid = 1'b0;
    n_cmp++; if (recv != NW) begin n_bad++; $display("FAIL rnd_timeout words got %0d want %0d", recv, NW); end
  endtask

  initial begin
    test_reset();
    test_four_beat();
    test_back_to_back();
    test_stall();
    test_nbeats();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
